// File: rtl/clk_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_pkg
// Shared types and constants for the programmable clock-enable divider.
//   clk_div_state_e : controller state (IDLE, RUN, PEND)
//   PULSE_CNT_WIDTH : width of the optional pulse statistics counter
// ---------------------------------------------------------------------------
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } clk_div_state_e;

    localparam int PULSE_CNT_WIDTH = 16;

endpackage : clk_div_ctrl_pkg

// File: rtl/clk_div_counter.sv
// ---------------------------------------------------------------------------
// clk_div_counter
// Period counter for the divider: counts 0..div_i-1 while enabled and
// derives the terminal pulse and the divided-clock level from it.
// Ports:
//   clk_200M_i  in   clock
//   rstn_i      in   synchronous active-low reset
//   clear_i     in   force the counter to 0 at the next edge
//   enable_i    in   count and drive the outputs
//   div_i       in   active ratio (never 0)
//   clk_en_o    out  high in the last cycle of each period
//   clk_div_o   out  high for the first div_i/2 cycles of each period
// ---------------------------------------------------------------------------
module clk_div_counter
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_200M_i,
    input  logic                 rstn_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 clk_en_o,
    output logic                 clk_div_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic                 terminal;

    // Kept separate from the next-state block so the FSM can use clk_en_o
    // to produce clear_i without forming a block-level loop.
    assign terminal  = (cnt_q == (div_i - DIV_WIDTH'(1)));
    assign clk_en_o  = enable_i && terminal;
    assign clk_div_o = enable_i && (cnt_q < (div_i >> 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = terminal ? '0 : cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_200M_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : clk_div_counter

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Programmable clock-enable divider. Emits a one-cycle enable pulse and a
// divided-clock level every active_div_o cycles. New ratios arrive over a
// valid/ready handshake and take effect only at a period boundary (or when
// the block is parked), so no period is ever truncated.
// Optional build macro: CLK_DIV_CTRL_STATS_EN adds pulse_cnt_o.
// Ports:
//   clk_200M_i    in   clock
//   rstn_i        in   synchronous active-low reset
//   en_i          in   run enable; low parks the block in IDLE
//   div_valid_i   in   ratio request
//   div_i         in   requested ratio (0 is rejected with err_o)
//   div_ready_o   out  request can be accepted (low while a ratio pends)
//   err_o         out  one-cycle pulse after a zero ratio was consumed
//   active_div_o  out  ratio currently in effect
//   clk_en_o      out  one-cycle enable pulse per period
//   clk_div_o     out  divided-clock level
//   pulse_cnt_o   out  (stats build) wrapping count of clk_en_o pulses
// ---------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clk_200M_i,
    input  logic                 rstn_i,
    input  logic                 en_i,
    input  logic                 div_valid_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 div_ready_o,
    output logic                 err_o,
    output logic [DIV_WIDTH-1:0] active_div_o,
    output logic                 clk_en_o,
    output logic                 clk_div_o
`ifdef CLK_DIV_CTRL_STATS_EN
    ,
    output logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_o
`endif
);

    localparam logic [DIV_WIDTH-1:0] DEFAULT_RATIO = DIV_WIDTH'(DEFAULT_DIV);

    clk_div_state_e       state_q, state_d;
    logic [DIV_WIDTH-1:0] active_q, active_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 req_ok;
    logic                 cnt_clear;
    logic                 cnt_enable;
    logic                 clk_en;

    // Ready depends on state only, so there is no valid-to-ready path.
    assign div_ready_o  = (state_q != PEND);
    assign accept       = div_valid_i && div_ready_o;
    assign req_ok       = accept && (div_i != '0);

    assign err_o        = err_q;
    assign active_div_o = active_q;
    assign clk_en_o     = clk_en;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        err_d    = accept && (div_i == '0);
        unique case (state_q)
            IDLE: begin
                if (req_ok) begin
                    active_d = div_i;
                end
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Disable wins over a simultaneous request; the new ratio
                // is applied directly since the block is parking anyway.
                if (!en_i) begin
                    state_d = IDLE;
                    if (req_ok) begin
                        active_d = div_i;
                    end
                end else if (req_ok) begin
                    pend_d  = div_i;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!en_i) begin
                    state_d  = IDLE;
                    active_d = pend_q;
                end else if (clk_en) begin
                    // Counter wraps to 0 on this same edge, so the new
                    // ratio starts with a full period.
                    active_d = pend_q;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Entering (or staying in) IDLE holds the counter at 0.
    assign cnt_clear  = (state_d == IDLE);
    assign cnt_enable = (state_q != IDLE);

    always_ff @(posedge clk_200M_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            active_q <= DEFAULT_RATIO;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    clk_div_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_counter (
        .clk_200M_i (clk_200M_i),
        .rstn_i     (rstn_i),
        .clear_i    (cnt_clear),
        .enable_i   (cnt_enable),
        .div_i      (active_q),
        .clk_en_o   (clk_en),
        .clk_div_o  (clk_div_o)
    );

`ifdef CLK_DIV_CTRL_STATS_EN
    logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;

    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (clk_en) begin
            pulse_cnt_d = pulse_cnt_q + PULSE_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_200M_i) begin
        if (!rstn_i) begin
            pulse_cnt_q <= '0;
        end else begin
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign pulse_cnt_o = pulse_cnt_q;
`else
    // No statistics: clk_en only feeds the FSM and the output.
`endif

endmodule : clk_div_ctrl
